// File: rtl/change_payout_ctrl.sv
// change_payout_ctrl: coin-hopper payout sequencer for a change dispenser.
// Pays a requested amount (whole units plus an optional half unit) by
// ejecting coins one at a time, largest first, while tracking hopper stock.
//
// Build option: define CHANGE_HALF_EN to enable the half-unit coin path.
// Without it, half coins are never selected, cnth reads 0, and any
// outstanding half unit ends the payout as short.
//
// Ports
//   clk_N       system clock (rising edge)
//   reset       asynchronous active-high reset
//   req         payout request, sampled only when idle
//   req_val     whole units to pay (0..31)
//   req_float   extra half unit to pay
//   refill      reload inventory to INIT values (idle only, wins over req)
//   hop_ack     hopper ejected one coin
//   hop_fire    eject request, held until hop_ack or timeout
//   hop_sel     coin select: 01=1-unit, 10=10-unit, 11=half, 00=none
//   busy        payout in progress
//   done        one-cycle pulse at end of every payout
//   short       last payout incomplete (sticky until next accepted req)
//   paid_val    whole units actually paid
//   paid_float  half unit actually paid
//   cnt10/cnt1/cnth  current inventory counts
module change_payout_ctrl #(
  parameter int unsigned INV10_INIT  = 4,
  parameter int unsigned INV1_INIT   = 20,
  parameter int unsigned INVH_INIT   = 10,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk_N,
  input  logic       reset,
  input  logic       req,
  input  logic [4:0] req_val,
  input  logic       req_float,
  input  logic       refill,
  input  logic       hop_ack,
  output logic       hop_fire,
  output logic [1:0] hop_sel,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [4:0] paid_val,
  output logic       paid_float,
  output logic [3:0] cnt10,
  output logic [4:0] cnt1,
  output logic [3:0] cnth
);

`ifdef CHANGE_HALF_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif

  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_10   = 2'b10;
  localparam logic [1:0] SEL_H    = 2'b11;

  // Half-coin stock is held at zero when the half path is not built.
  localparam logic [3:0] CNTH_RST = HALF_EN ? 4'(INVH_INIT) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FIRE,
    S_DONE,
    S_SHORT
  } state_t;

  state_t           state;
  logic [4:0]       rem;
  logic             rem_f;
  logic [TMO_W-1:0] tmo;

  // Sequencer: state, hopper handshake, remaining/paid amounts, inventory.
  always_ff @(posedge clk_N or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hop_fire   <= 1'b0;
      hop_sel    <= SEL_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      paid_val   <= '0;
      paid_float <= 1'b0;
      cnt10      <= 4'(INV10_INIT);
      cnt1       <= 5'(INV1_INIT);
      cnth       <= CNTH_RST;
      rem        <= '0;
      rem_f      <= 1'b0;
      tmo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (refill) begin
            cnt10 <= 4'(INV10_INIT);
            cnt1  <= 5'(INV1_INIT);
            cnth  <= CNTH_RST;
          end else if (req) begin
            rem        <= req_val;
            rem_f      <= req_float;
            paid_val   <= '0;
            paid_float <= 1'b0;
            short      <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CHECK;
          end
        end

        // Largest coin first; every decrement is guarded by a nonzero count.
        S_CHECK: begin
          tmo <= '0;
          if (rem >= 5'd10 && cnt10 != 4'd0) begin
            hop_fire <= 1'b1;
            hop_sel  <= SEL_10;
            state    <= S_FIRE;
          end else if (rem >= 5'd1 && cnt1 != 5'd0) begin
            hop_fire <= 1'b1;
            hop_sel  <= SEL_1;
            state    <= S_FIRE;
          end else if (HALF_EN && rem_f && cnth != 4'd0) begin
            hop_fire <= 1'b1;
            hop_sel  <= SEL_H;
            state    <= S_FIRE;
          end else if (rem == 5'd0 && !rem_f) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            done  <= 1'b1;
            short <= 1'b1;
            state <= S_SHORT;
          end
        end

        // Hold the eject request until the hopper acknowledges or gives up.
        S_FIRE: begin
          if (hop_ack) begin
            hop_fire <= 1'b0;
            hop_sel  <= SEL_NONE;
            state    <= S_CHECK;
            case (hop_sel)
              SEL_10: begin
                cnt10    <= cnt10 - 4'd1;
                rem      <= rem - 5'd10;
                paid_val <= paid_val + 5'd10;
              end
              SEL_1: begin
                cnt1     <= cnt1 - 5'd1;
                rem      <= rem - 5'd1;
                paid_val <= paid_val + 5'd1;
              end
              SEL_H: begin
                cnth       <= cnth - 4'd1;
                rem_f      <= 1'b0;
                paid_float <= 1'b1;
              end
              default: ;
            endcase
          end else if (tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
            // Coin not confirmed: abandon the payout, inventory untouched.
            hop_fire <= 1'b0;
            hop_sel  <= SEL_NONE;
            done     <= 1'b1;
            short    <= 1'b1;
            state    <= S_SHORT;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        S_DONE, S_SHORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Scoreboard bench for change_payout_ctrl: directed payouts push their
// hand-computed result; a monitor compares it on every done pulse.
module tb_change_payout_ctrl;

`ifdef CHANGE_HALF_EN
  localparam bit HALF = 1'b1;
  localparam logic [3:0] CH_INIT = 4'd10;
`else
  localparam bit HALF = 1'b0;
  localparam logic [3:0] CH_INIT = 4'd0;
`endif

  logic       clk_N;
  logic       reset;
  logic       req;
  logic [4:0] req_val;
  logic       req_float;
  logic       refill;
  logic       hop_ack;
  logic       hop_fire;
  logic [1:0] hop_sel;
  logic       busy;
  logic       done;
  logic       short;
  logic [4:0] paid_val;
  logic       paid_float;
  logic [3:0] cnt10;
  logic [4:0] cnt1;
  logic [3:0] cnth;

  logic hp_ack;
  logic stray_ack;
  assign hop_ack = hp_ack | stray_ack;

  change_payout_ctrl dut (
    .clk_N     (clk_N),
    .reset     (reset),
    .req       (req),
    .req_val   (req_val),
    .req_float (req_float),
    .refill    (refill),
    .hop_ack   (hop_ack),
    .hop_fire  (hop_fire),
    .hop_sel   (hop_sel),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .paid_val  (paid_val),
    .paid_float(paid_float),
    .cnt10     (cnt10),
    .cnt1      (cnt1),
    .cnth      (cnth)
  );

  typedef struct {
    logic [4:0]  pv;
    logic        pf;
    logic        sh;
    logic [3:0]  c10;
    logic [4:0]  c1;
    logic [3:0]  ch;
    logic [31:0] seq;
    int          nsel;
  } resp_t;

  resp_t q[$];
  int checks = 0;
  int errors = 0;
  int ack_delay = 2;
  bit no_ack = 1'b0;

  initial begin
    clk_N = 1'b0;
    forever #5 clk_N = ~clk_N;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [4:0] pv, input logic pf, input logic sh,
                             input logic [3:0] c10, input logic [4:0] c1, input logic [3:0] ch,
                             input logic [31:0] seq, input int nsel);
    resp_t r;
    r.pv = pv; r.pf = pf; r.sh = sh; r.c10 = c10; r.c1 = c1; r.ch = ch;
    r.seq = seq; r.nsel = nsel;
    q.push_back(r);
  endtask

  // Hopper model: acknowledges each fire after ack_delay cycles.
  initial begin
    int wait_cnt;
    hp_ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(posedge clk_N);
      #1;
      if (hp_ack) begin
        hp_ack = 1'b0;
        wait_cnt = 0;
      end else if (hop_fire && !no_ack) begin
        if (wait_cnt >= ack_delay) begin
          hp_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: records accepted coin selects, checks the result on done.
  initial begin
    logic [31:0] mseq;
    int mn;
    resp_t e;
    mseq = '0;
    mn = 0;
    forever begin
      @(negedge clk_N);
      if (reset) begin
        mseq = '0;
        mn = 0;
      end else begin
        if (hop_fire && hop_ack) begin
          mseq = {mseq[29:0], hop_sel};
          mn++;
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            check("paid_val", 32'(paid_val), 32'(e.pv));
            check("paid_float", 32'(paid_float), 32'(e.pf));
            check("short", 32'(short), 32'(e.sh));
            check("cnt10", 32'(cnt10), 32'(e.c10));
            check("cnt1", 32'(cnt1), 32'(e.c1));
            check("cnth", 32'(cnth), 32'(e.ch));
            check("sel_seq", mseq, e.seq);
            check("sel_count", 32'(mn), 32'(e.nsel));
          end
          mseq = '0;
          mn = 0;
        end
      end
    end
  end

  task automatic do_req(input logic [4:0] v, input logic f, input logic rf);
    @(negedge clk_N);
    req = 1'b1; req_val = v; req_float = f; refill = rf;
    @(posedge clk_N);
    #1;
    req = 1'b0; refill = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int fires);
    cyc = 0;
    fires = 0;
    while (1) begin
      @(negedge clk_N);
      cyc++;
      if (hop_fire) fires++;
      if (done) break;
      if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_N);
    reset = 1'b1;
    @(negedge clk_N);
    @(negedge clk_N);
    reset = 1'b0;
  endtask

  initial begin
    int cyc, fires;
    req = 1'b0; req_val = '0; req_float = 1'b0; refill = 1'b0;
    stray_ack = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_N);
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hop_fire", 32'(hop_fire), 32'd0);
    check("rst_hop_sel", 32'(hop_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_short", 32'(short), 32'd0);
    check("rst_paid", 32'({paid_val, paid_float}), 32'd0);
    check("rst_cnt10", 32'(cnt10), 32'd4);
    check("rst_cnt1", 32'(cnt1), 32'd20);
    check("rst_cnth", 32'(cnth), 32'(CH_INIT));

    // Stray ack while idle is ignored
    @(negedge clk_N);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk_N);
    stray_ack = 1'b0;
    @(negedge clk_N);
    check("stray_ack_busy", 32'(busy), 32'd0);
    check("stray_ack_cnt", 32'({cnt10, cnt1, cnth}), 32'({4'd4, 5'd20, CH_INIT}));

    // 13 units: one 10-coin, three 1-coins; a request while busy is dropped
    expect_resp(5'd13, 1'b0, 1'b0, 4'd3, 5'd17, CH_INIT, 32'h95, 4);
    do_req(5'd13, 1'b0, 1'b0);
    repeat (3) @(negedge clk_N);
    check("busy_during_payout", 32'(busy), 32'd1);
    req = 1'b1; req_val = 5'd1;
    @(posedge clk_N);
    #1 req = 1'b0;
    wait_done(200, cyc, fires);

    // Five payouts of 10 after reset: 10-coins run out on the fifth
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_resp(5'd10, 1'b0, 1'b0, 4'(3 - i), 5'd20, CH_INIT, 32'h2, 1);
      do_req(5'd10, 1'b0, 1'b0);
      wait_done(100, cyc, fires);
    end
    expect_resp(5'd10, 1'b0, 1'b0, 4'd0, 5'd10, CH_INIT, 32'h55555, 10);
    do_req(5'd10, 1'b0, 1'b0);
    wait_done(300, cyc, fires);

    // 12 units with only ten 1-coins left: short, stock stops at zero
    expect_resp(5'd10, 1'b0, 1'b1, 4'd0, 5'd0, CH_INIT, 32'h55555, 10);
    do_req(5'd12, 1'b0, 1'b0);
    wait_done(300, cyc, fires);

    // Zero request: done 2 cycles after req, short cleared on accept
    expect_resp(5'd0, 1'b0, 1'b0, 4'd0, 5'd0, CH_INIT, 32'h0, 0);
    do_req(5'd0, 1'b0, 1'b0);
    check("short_cleared_on_req", 32'(short), 32'd0);
    wait_done(20, cyc, fires);
    check("zero_req_latency", 32'(cyc), 32'd2);
    check("zero_req_fires", 32'(fires), 32'd0);

    // Refill together with req: refill wins, no payout starts
    do_req(5'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_N);
      check("refill_busy", 32'(busy), 32'd0);
    end
    check("refill_cnt10", 32'(cnt10), 32'd4);
    check("refill_cnt1", 32'(cnt1), 32'd20);
    check("refill_cnth", 32'(cnth), 32'(CH_INIT));

    // Hopper never acks: fire held 15 cycles, then short with stock intact
    no_ack = 1'b1;
    expect_resp(5'd0, 1'b0, 1'b1, 4'd4, 5'd20, CH_INIT, 32'h0, 0);
    do_req(5'd5, 1'b0, 1'b0);
    wait_done(100, cyc, fires);
    check("timeout_fire_cycles", 32'(fires), 32'd15);
    no_ack = 1'b0;
    repeat (3) @(negedge clk_N);
    check("short_sticky", 32'(short), 32'd1);

    // 2.5 units: half coin with the half path, short without it
    if (HALF)
      expect_resp(5'd2, 1'b1, 1'b0, 4'd4, 5'd18, 4'd9, 32'h17, 3);
    else
      expect_resp(5'd2, 1'b0, 1'b1, 4'd4, 5'd18, 4'd0, 32'h5, 2);
    do_req(5'd2, 1'b1, 1'b0);
    check("short_cleared_on_req2", 32'(short), 32'd0);
    wait_done(200, cyc, fires);

    // Reset while a 10-coin is being fired
    no_ack = 1'b1;
    do_req(5'd10, 1'b0, 1'b0);
    cyc = 0;
    while (!hop_fire && cyc < 10) begin
      @(negedge clk_N);
      cyc++;
    end
    check("fire_sel_10", 32'(hop_sel), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("midfire_hop_fire", 32'(hop_fire), 32'd0);
    check("midfire_hop_sel", 32'(hop_sel), 32'd0);
    check("midfire_busy", 32'(busy), 32'd0);
    check("midfire_cnt10", 32'(cnt10), 32'd4);
    check("midfire_cnt1", 32'(cnt1), 32'd20);
    @(negedge clk_N);
    reset = 1'b0;
    no_ack = 1'b0;

    // 31 units with zero ack delay: three 10-coins and one 1-coin
    ack_delay = 0;
    expect_resp(5'd31, 1'b0, 1'b0, 4'd1, 5'd19, CH_INIT, 32'hA9, 4);
    do_req(5'd31, 1'b0, 1'b0);
    wait_done(100, cyc, fires);

    repeat (5) @(negedge clk_N);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
